// File: rtl/neuron_pkg.sv
// neuron_pkg: constants shared across the neuron output-queue slice.
//   OVF_DROP_NEW  - overflow policy: discard the incoming word when full
//   OVF_DROP_OLD  - overflow policy: overwrite the oldest word when full
//   NEURON_DATA_W - default width of one spike/event word
package neuron_pkg;

  localparam int OVF_DROP_NEW  = 32'd0;
  localparam int OVF_DROP_OLD  = 32'h1;
  localparam int NEURON_DATA_W = 32'd8;

endpackage : neuron_pkg

// File: rtl/neuron_outq_fifo_if.sv
// neuron_outq_fifo_if: producer/consumer bundle of the neuron output queue.
//   ena         block enable, low flushes the queue on the next edge
//   emit_valid  push request, emit_data is the pushed word
//   out_fire    pop of the head word (ignored while empty)
//   clr_drop    synchronous clear of drop_count
//   have_out    queue non-empty, out_data is the head word (zero when empty)
//   full        occupancy equals DEPTH, level is the occupancy
//   drop_count  saturating count of words lost to overflow
// master: the side that drives requests; slave: the queue itself.
interface neuron_outq_fifo_if
  import neuron_pkg::*;
#(
  parameter int DATA_W = NEURON_DATA_W,
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
);

  logic                     ena;
  logic                     emit_valid;
  logic [DATA_W-1:0]        emit_data;
  logic                     out_fire;
  logic                     clr_drop;
  logic                     have_out;
  logic [DATA_W-1:0]        out_data;
  logic                     full;
  logic [$clog2(DEPTH):0]   level;
  logic [DROP_W-1:0]        drop_count;

  modport master (
    output ena, emit_valid, emit_data, out_fire, clr_drop,
    input  have_out, out_data, full, level, drop_count
  );

  modport slave (
    input  ena, emit_valid, emit_data, out_fire, clr_drop,
    output have_out, out_data, full, level, drop_count
  );

endinterface : neuron_outq_fifo_if

// File: rtl/neuron_outq_fifo.sv
// neuron_outq_fifo: show-ahead output queue for spike/event words.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (empties queue, clears drop count)
//   q    neuron_outq_fifo_if.slave bundle (see interface header)
// OVF_MODE selects what a push into a full queue does when no pop happens
// in the same cycle: OVF_DROP_NEW discards the new word, OVF_DROP_OLD
// retires the head and stores the new word. Either way the loss is counted.
module neuron_outq_fifo
  import neuron_pkg::*;
#(
  parameter int DATA_W   = NEURON_DATA_W,
  parameter int DEPTH    = 4,
  parameter int DROP_W   = 8,
  parameter int OVF_MODE = OVF_DROP_NEW
) (
  input  logic               clk,
  input  logic               rst,
  neuron_outq_fifo_if.slave  q
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [LVL_W-1:0]  level_r;
  logic [DROP_W-1:0] drop_r;
  logic              have_out_r;
  logic              full_r;

  logic              pop_s;
  logic              push_s;
  logic              drop_s;
  logic              adv_rd_s;
  logic [LVL_W-1:0]  level_nxt_s;
  logic [DROP_W-1:0] drop_nxt_s;

  // Decode the cycle's push/pop/drop actions and the next level/drop count.
  always_comb begin
    pop_s       = q.out_fire && have_out_r;
    drop_s      = q.emit_valid && full_r && !pop_s;
    // A push is stored unless it is a drop-new overflow.
    push_s      = q.emit_valid && !(drop_s && (OVF_MODE != OVF_DROP_OLD));
    // Overwrite-oldest retires the head to make room for the new word.
    adv_rd_s    = pop_s || (drop_s && (OVF_MODE == OVF_DROP_OLD));
    level_nxt_s = level_r;
    drop_nxt_s  = drop_r;
    if (push_s && !adv_rd_s) begin
      level_nxt_s = level_r + LVL_W'(1);
    end else if (adv_rd_s && !push_s) begin
      level_nxt_s = level_r - LVL_W'(1);
    end else begin
      level_nxt_s = level_r;
    end
    // A clear coinciding with a drop still records that drop.
    if (q.clr_drop) begin
      drop_nxt_s = drop_s ? DROP_W'(1) : '0;
    end else if (drop_s && (drop_r != {DROP_W{1'b1}})) begin
      drop_nxt_s = drop_r + DROP_W'(1);
    end else begin
      drop_nxt_s = drop_r;
    end
  end

  // Pointer, occupancy and drop-count registers with flush on ena low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level_r    <= '0;
      drop_r     <= '0;
      have_out_r <= 1'b0;
      full_r     <= 1'b0;
    end else if (!q.ena) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level_r    <= '0;
      drop_r     <= '0;
      have_out_r <= 1'b0;
      full_r     <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (adv_rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      level_r    <= level_nxt_s;
      drop_r     <= drop_nxt_s;
      have_out_r <= (level_nxt_s != '0);
      full_r     <= (level_nxt_s == LVL_W'(DEPTH));
    end
  end

  // Word storage; contents are never cleared, only pointers are.
  always_ff @(posedge clk) begin
    if (q.ena && push_s) begin
      mem_r[wr_ptr_r] <= q.emit_data;
    end
  end

  // Head word is gated so stale storage never leaks out while empty.
  always_comb begin
    if (have_out_r) begin
      q.out_data = mem_r[rd_ptr_r];
    end else begin
      q.out_data = '0;
    end
  end

  assign q.have_out   = have_out_r;
  assign q.full       = full_r;
  assign q.level      = level_r;
  assign q.drop_count = drop_r;

endmodule : neuron_outq_fifo
